// File: rtl/ram_io_responder_pkg.sv
// Shared definitions for the RAM/I-O responder: bus encodings, I/O window map, status bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_io_responder_pkg;

    // Bus direction as driven by the memory controller
    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } rw_e;

    // I/O window: any address whose bits [17:16] match IO_BASE is I/O
    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [1:0]  IO_SEL  = IO_BASE[17:16];

    // Register offsets inside the I/O window (addr[2:0])
    localparam logic [2:0] IO_DATA = 3'd0;
    localparam logic [2:0] IO_CTRL = 3'd4;

    // Status byte bit positions returned by an IO_CTRL read
    localparam int ST_TX_FULL     = 0;
    localparam int ST_RX_NONEMPTY = 1;
    localparam int ST_OVERFLOW    = 2;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[17:16] == IO_SEL;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Byte-serial RAM bus plus host console signals, grouped as one bundle.
// Latency: n/a (wiring only).
// Backpressure: host side uses valid/ready; RAM bus side has none.
interface ram_io_responder_if;
    logic        ramEn_in;
    logic        ramRW_in;
    logic [31:0] ramAddr_in;
    logic [7:0]  ramData_in;
    logic [7:0]  ramData_out;
    logic [7:0]  ioTxData_out;
    logic        ioTxValid_out;
    logic        ioTxReady_in;
    logic [7:0]  ioRxData_in;
    logic        ioRxValid_in;
    logic        ioRxReady_out;
    logic        halt_out;

    // Responder side (the design)
    modport slave (
        input  ramEn_in, ramRW_in, ramAddr_in, ramData_in,
        input  ioTxReady_in, ioRxData_in, ioRxValid_in,
        output ramData_out, ioTxData_out, ioTxValid_out, ioRxReady_out, halt_out
    );

    // Controller/host side
    modport master (
        output ramEn_in, ramRW_in, ramAddr_in, ramData_in,
        output ioTxReady_in, ioRxData_in, ioRxValid_in,
        input  ramData_out, ioTxData_out, ioTxValid_out, ioRxReady_out, halt_out
    );
endinterface

// File: rtl/ram_io_responder_sync_fifo.sv
// Generic single-clock FIFO with show-ahead head output.
// Latency: push visible at head one cycle later; pop takes effect at the edge.
// Backpressure: push when full is accepted only if a pop happens the same cycle; pop when empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage: no reset needed, only slots covered by the count are ever read meaningfully
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped console FIFOs, status and halt, served one byte access per cycle.
// Latency: reads return on ramData_out one cycle after presentation; writes land at the edge.
// Backpressure: none on the RAM bus (TX overflow drops the byte and sets a sticky flag); host side valid/ready.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    ram_io_responder_if.slave    bus
);
    logic [7:0]            r_mem [2**ADDR_WIDTH];
    logic [7:0]            r_rd_dat;
    logic                  r_halt;
    logic                  r_overflow;

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_is_io;
    logic [2:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [7:0]            w_io_rd_dat;
    logic [7:0]            w_status;

    logic                  w_tx_full;
    logic                  w_tx_empty;
    logic [7:0]            w_tx_head;
    logic                  w_tx_push;
    logic                  w_tx_host_pop;

    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic [7:0]            w_rx_head;
    logic                  w_rx_pop;
    logic                  w_rx_host_push;

    // Address decode; bits above the RAM index alias unless they select the I/O window
    assign w_rd    = bus.ramEn_in & (bus.ramRW_in == RW_READ);
    assign w_wr    = bus.ramEn_in & (bus.ramRW_in == RW_WRITE);
    assign w_is_io = is_io_addr(bus.ramAddr_in);
    assign w_off   = bus.ramAddr_in[2:0];
    assign w_idx   = bus.ramAddr_in[ADDR_WIDTH-1:0];

    // FIFO control, bus side and host side are independent
    assign w_tx_push      = w_wr & w_is_io & (w_off == IO_DATA);
    assign w_tx_host_pop  = bus.ioTxReady_in & ~w_tx_empty;
    assign w_rx_pop       = w_rd & w_is_io & (w_off == IO_DATA);
    assign w_rx_host_push = bus.ioRxValid_in & ~w_rx_full;

    // Status reflects state before this cycle's FIFO updates
    always_comb begin
        w_status                 = 8'h00;
        w_status[ST_TX_FULL]     = w_tx_full;
        w_status[ST_RX_NONEMPTY] = ~w_rx_empty;
        w_status[ST_OVERFLOW]    = r_overflow;
    end

    // I/O read mux; an empty RX reads as zero and pops nothing
    always_comb begin
        w_io_rd_dat = 8'h00;
        case (w_off)
            IO_DATA: w_io_rd_dat = w_rx_empty ? 8'h00 : w_rx_head;
            IO_CTRL: w_io_rd_dat = w_status;
            default: w_io_rd_dat = 8'h00;
        endcase
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (w_wr && !w_is_io) begin
            r_mem[w_idx] <= bus.ramData_in;
        end
    end

    // Registered read data; holds across idle cycles and writes
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_dat <= 8'h00;
        end else if (w_rd) begin
            r_rd_dat <= w_is_io ? w_io_rd_dat : r_mem[w_idx];
        end
    end

    // Sticky halt and TX overflow flags, cleared only by reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_halt     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr && w_is_io && (w_off == IO_CTRL)) r_halt <= 1'b1;
            if (w_tx_push && w_tx_full && !w_tx_host_pop) r_overflow <= 1'b1;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_in),
        .i_push  (w_tx_push),
        .i_dat   (bus.ramData_in),
        .i_pop   (w_tx_host_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_in),
        .i_push  (w_rx_host_push),
        .i_dat   (bus.ioRxData_in),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

    assign bus.ramData_out   = r_rd_dat;
    assign bus.ioTxData_out  = w_tx_head;
    assign bus.ioTxValid_out = ~w_tx_empty;
    assign bus.ioRxReady_out = ~w_rx_full;
    assign bus.halt_out      = r_halt;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed plus randomized bench for ram_io_responder against a queue-based reference model.
// Latency: inputs applied after an edge, outputs compared 1ns after the following edge.
// Backpressure: host TX ready and RX valid are driven directly by the bench.
module tb_ram_io_responder;
    import ram_io_responder_pkg::*;

    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_io_responder_if bus();

    ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_mem [int];
    logic [7:0] m_txq [$];
    logic [7:0] m_rxq [$];
    logic       m_halt = 1'b0;
    logic       m_ovf  = 1'b0;
    logic [7:0] m_rd   = 8'h00;
    int         wr_idx [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rw, input logic [31:0] addr, input logic [7:0] wd,
                         input logic txrdy, input logic rxvld, input logic [7:0] rxd);
        bus.ramEn_in     = en;
        bus.ramRW_in     = rw;
        bus.ramAddr_in   = addr;
        bus.ramData_in   = wd;
        bus.ioTxReady_in = txrdy;
        bus.ioRxValid_in = rxvld;
        bus.ioRxData_in  = rxd;
    endtask

    // One clock of the model, computed from the pre-edge state
    task automatic model_step(input logic en, input logic rw, input logic [31:0] addr, input logic [7:0] wd,
                              input logic txrdy, input logic rxvld, input logic [7:0] rxd);
        bit host_tx_pop  = txrdy && (m_txq.size() > 0);
        bit host_rx_push = rxvld && (m_rxq.size() < DEPTH);
        bit tx_full_old  = (m_txq.size() == DEPTH);
        bit rx_ne_old    = (m_rxq.size() > 0);
        bit ovf_old      = m_ovf;
        bit bus_tx_push  = 0;
        bit bus_rx_pop   = 0;
        int idx          = int'(addr[16:0]);
        if (en) begin
            if (addr[17:16] != 2'b11) begin
                if (rw) m_mem[idx] = wd;
                else    m_rd = m_mem.exists(idx) ? m_mem[idx] : 8'hxx;
            end else begin
                case (addr[2:0])
                    3'd0: begin
                        if (rw) begin
                            if (!tx_full_old || host_tx_pop) bus_tx_push = 1;
                            else m_ovf = 1'b1;
                        end else if (rx_ne_old) begin
                            m_rd = m_rxq[0];
                            bus_rx_pop = 1;
                        end else begin
                            m_rd = 8'h00;
                        end
                    end
                    3'd4: begin
                        if (rw) m_halt = 1'b1;
                        else    m_rd = {5'b0, ovf_old, rx_ne_old, tx_full_old};
                    end
                    default: if (!rw) m_rd = 8'h00;
                endcase
            end
        end
        if (host_tx_pop)  void'(m_txq.pop_front());
        if (bus_tx_push)  m_txq.push_back(wd);
        if (bus_rx_pop)   void'(m_rxq.pop_front());
        if (host_rx_push) m_rxq.push_back(rxd);
    endtask

    task automatic compare_outputs();
        check("rdata", {24'h0, bus.ramData_out}, {24'h0, m_rd});
        check("tx_vld", {31'h0, bus.ioTxValid_out}, {31'h0, m_txq.size() > 0});
        if (m_txq.size() > 0) check("tx_dat", {24'h0, bus.ioTxData_out}, {24'h0, m_txq[0]});
        check("rx_rdy", {31'h0, bus.ioRxReady_out}, {31'h0, m_rxq.size() < DEPTH});
        check("halt", {31'h0, bus.halt_out}, {31'h0, m_halt});
    endtask

    task automatic cycle(input logic en, input logic rw, input logic [31:0] addr, input logic [7:0] wd,
                         input logic txrdy, input logic rxvld, input logic [7:0] rxd);
        drive(en, rw, addr, wd, txrdy, rxvld, rxd);
        @(posedge clk);
        #1;
        model_step(en, rw, addr, wd, txrdy, rxvld, rxd);
        if (en && !rw && addr[17:16] != 2'b11) wr_idx.push_back(0);
        if (en && !rw && addr[17:16] != 2'b11) void'(wr_idx.pop_back());
        if (en && rw && addr[17:16] != 2'b11) wr_idx.push_back(int'(addr[16:0]));
        compare_outputs();
    endtask

    // Asynchronous reset pulse placed mid-cycle, well away from the rising edge
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rdata", {24'h0, bus.ramData_out}, 32'h0);
        check("rst_halt", {31'h0, bus.halt_out}, 32'h0);
        check("rst_tx_vld", {31'h0, bus.ioTxValid_out}, 32'h0);
        drive(1'b0, RW_READ, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
        m_txq.delete();
        m_rxq.delete();
        m_halt = 1'b0;
        m_ovf  = 1'b0;
        m_rd   = 8'h00;
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_rx_rdy", {31'h0, bus.ioRxReady_out}, 32'h1);
    endtask

    initial begin
        logic [7:0]  burst [4];
        logic [31:0] u;
        logic [31:0] a;
        logic [16:0] ridx;
        burst[0] = 8'h12; burst[1] = 8'h34; burst[2] = 8'h56; burst[3] = 8'h78;

        // Power-on reset
        drive(1'b0, RW_READ, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
        #2;
        check("por_rdata", {24'h0, bus.ramData_out}, 32'h0);
        check("por_halt", {31'h0, bus.halt_out}, 32'h0);
        check("por_tx_vld", {31'h0, bus.ioTxValid_out}, 32'h0);
        #8;
        rst_n = 1'b1;
        #1;
        check("por_rx_rdy", {31'h0, bus.ioRxReady_out}, 32'h1);

        // Write burst then back-to-back reads
        for (int i = 0; i < 4; i++) cycle(1'b1, RW_WRITE, 32'h100 + i, burst[i], 1'b0, 1'b0, 8'h00);
        check("wr_holds_rdata", {24'h0, bus.ramData_out}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, RW_READ, 32'h100 + i, 8'h00, 1'b0, 1'b0, 8'h00);
            check("burst_rd", {24'h0, bus.ramData_out}, {24'h0, burst[i]});
        end

        // Aliasing: upper address bits outside the I/O decode are ignored
        cycle(1'b1, RW_WRITE, 32'h0000_1234, 8'h9C, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, RW_READ, 32'hABC0_1234, 8'h00, 1'b0, 1'b0, 8'h00);
        check("alias_rd", {24'h0, bus.ramData_out}, 32'h9C);

        // Reset in the middle of a read burst; RAM survives
        cycle(1'b1, RW_READ, 32'h100, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, RW_READ, 32'h101, 8'h00, 1'b0, 1'b0, 8'h00);
        apply_reset();
        cycle(1'b1, RW_READ, 32'h102, 8'h00, 1'b0, 1'b0, 8'h00);
        check("ram_retained", {24'h0, bus.ramData_out}, 32'h56);

        // RX byte must not be popped by a disabled read
        cycle(1'b0, RW_READ, 32'h0, 8'h00, 1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) cycle(1'b0, RW_READ, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, RW_READ, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx_pop_a5", {24'h0, bus.ramData_out}, 32'hA5);
        cycle(1'b1, RW_READ, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
        check("rx_empty_rd", {24'h0, bus.ramData_out}, 32'h00);

        // TX overflow: 9 pushes into a depth-8 FIFO
        apply_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, RW_WRITE, 32'h30000, 8'(i + 1), 1'b0, 1'b0, 8'h00);
        cycle(1'b1, RW_READ, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
        check("ovf_status", {24'h0, bus.ramData_out}, 32'h05);
        for (int i = 0; i < 8; i++) begin
            check("drain_dat", {24'h0, bus.ioTxData_out}, 32'(i + 1));
            cycle(1'b0, RW_READ, 32'h0, 8'h00, 1'b1, 1'b0, 8'h00);
        end
        check("drain_vld_low", {31'h0, bus.ioTxValid_out}, 32'h0);

        // Full TX with same-cycle host pop accepts the push without overflow
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, RW_WRITE, 32'h30000, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
        cycle(1'b1, RW_WRITE, 32'h30000, 8'hEE, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, RW_READ, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
        check("full_pop_status", {24'h0, bus.ramData_out}, 32'h01);
        check("full_pop_head", {24'h0, bus.ioTxData_out}, 32'h41);
        for (int i = 0; i < 8; i++) cycle(1'b0, RW_READ, 32'h0, 8'h00, 1'b1, 1'b0, 8'h00);

        // Halt is sticky until reset
        cycle(1'b1, RW_WRITE, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
        check("halt_set", {31'h0, bus.halt_out}, 32'h1);
        for (int i = 0; i < 3; i++) cycle(1'b1, RW_WRITE, 32'h200 + i, 8'(i), 1'b1, 1'b1, 8'(i));
        check("halt_sticky", {31'h0, bus.halt_out}, 32'h1);
        apply_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int   op    = $urandom_range(0, 9);
            logic en    = ($urandom_range(0, 9) != 0);
            logic txrdy = 1'($urandom_range(0, 1));
            logic rxvld = 1'($urandom_range(0, 1));
            logic [7:0] rxd = 8'($urandom);
            logic [7:0] wd  = 8'($urandom);
            logic rw;
            u = $urandom;
            if (op <= 4 && (op <= 2 || wr_idx.size() == 0)) begin
                ridx = 17'($urandom);
                a  = {u[31:18], 1'b0, ridx};
                rw = RW_WRITE;
            end else if (op <= 4) begin
                ridx = 17'(wr_idx[$urandom_range(0, wr_idx.size() - 1)]);
                a  = {u[31:18], 1'b0, ridx};
                rw = RW_READ;
            end else if (op <= 6) begin
                a  = {u[31:18], 2'b11, u[15:3], 3'd0};
                rw = RW_WRITE;
            end else if (op == 7) begin
                a  = {u[31:18], 2'b11, u[15:3], 3'd0};
                rw = RW_READ;
            end else if (op == 8) begin
                a  = {u[31:18], 2'b11, u[15:3], 3'd4};
                rw = RW_READ;
            end else begin
                logic [2:0] off = 3'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) off = off + 3'd4;
                a  = {u[31:18], 2'b11, u[15:3], off};
                rw = 1'($urandom_range(0, 1));
            end
            cycle(en, rw, a, wd, txrdy, rxvld, rxd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
